// File: rtl/mmio_uart_pkg.sv
// rtl/mmio_uart_pkg.sv - register map, STATUS bit positions and FSM state types for mmio_uart
package mmio_uart_pkg;

    localparam logic [1:0] REG_TXDATA   = 2'd0;
    localparam logic [1:0] REG_RXDATA   = 2'd1;
    localparam logic [1:0] REG_STATUS   = 2'd2;
    localparam logic [1:0] REG_BAUD_DIV = 2'd3;

    localparam int ST_TX_FULL  = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_TX_BUSY  = 2;
    localparam int ST_RX_VALID = 3;
    localparam int ST_OVERRUN  = 4;
    localparam int ST_FERR     = 5;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // A divider below 2 would leave the RX half-bit counter with nothing to count.
    function automatic logic [15:0] clamp_div(input logic [15:0] v);
        return (v < 16'd2) ? 16'd2 : v;
    endfunction

endpackage

// File: rtl/mmio_uart_sync_fifo.sv
// rtl/mmio_uart_sync_fifo.sv - single-clock FIFO with extra-bit pointers for full/empty
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop && !empty)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mmio_uart.sv
// rtl/mmio_uart.sv - zero-wait MMIO UART: register decode, TX FIFO + 8N1 serialiser, RX deserialiser
module mmio_uart
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
    parameter int          TX_DEPTH    = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd868,
    parameter int          DATA_WIDTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [31:0]           i_mmio_addr,
    input  logic [DATA_WIDTH-1:0] i_mmio_data,
    input  logic                  i_mmio_wr_valid,
    output logic                  o_mmio_wr_ready,
    output logic [DATA_WIDTH-1:0] o_mmio_data,
    output logic                  o_mmio_rd_valid,
    input  logic                  i_mmio_rd_ready,
    output logic                  o_tx,
    input  logic                  i_rx
);

    logic       hit;
    logic [1:0] reg_sel;
    logic       tx_push, rx_pop, sts_wr;
    logic       fifo_full, fifo_empty, fifo_pop;
    logic [7:0] fifo_data;
    logic [15:0] baud_div;

    tx_state_t  tx_state;
    logic [15:0] tx_cnt;
    logic [7:0] tx_shift;
    logic [2:0] tx_bit;

    rx_state_t  rx_state;
    logic       rx_s1, rx_s2, rx_d;
    logic [15:0] rx_cnt;
    logic [7:0] rx_shift;
    logic [2:0] rx_bit;
    logic [7:0] rx_byte;
    logic       rx_valid, overrun, ferr;

    logic [5:0]            status;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  data_unused;

    assign data_unused = ^i_mmio_data[DATA_WIDTH-1:16];

    assign reg_sel = i_mmio_addr[3:2];
    assign hit     = (i_mmio_addr[31:4] == BASE_ADDR[31:4]) && (i_mmio_addr[1:0] == 2'b00);

    // Full FIFO stalls the write even if the TX FSM pops this same cycle.
    assign o_mmio_wr_ready = hit && i_mmio_wr_valid && ((reg_sel != REG_TXDATA) || !fifo_full);
    assign o_mmio_rd_valid = hit && i_mmio_rd_ready;

    assign tx_push = o_mmio_wr_ready && (reg_sel == REG_TXDATA);
    assign sts_wr  = o_mmio_wr_ready && (reg_sel == REG_STATUS);
    assign rx_pop  = o_mmio_rd_valid && (reg_sel == REG_RXDATA);

    always_comb begin
        status              = '0;
        status[ST_TX_FULL]  = fifo_full;
        status[ST_TX_EMPTY] = fifo_empty && (tx_state == TX_IDLE);
        status[ST_TX_BUSY]  = (tx_state != TX_IDLE);
        status[ST_RX_VALID] = rx_valid;
        status[ST_OVERRUN]  = overrun;
        status[ST_FERR]     = ferr;
    end

    always_comb begin
        rdata = '0;
        if (o_mmio_rd_valid) begin
            case (reg_sel)
                REG_RXDATA:   if (rx_valid) rdata[7:0] = rx_byte;
                REG_STATUS:   rdata[5:0] = status;
                REG_BAUD_DIV: rdata[15:0] = baud_div;
                default:      rdata = '0;
            endcase
        end
    end
    assign o_mmio_data = rdata;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            baud_div <= DEFAULT_DIV;
        else if (o_mmio_wr_ready && (reg_sel == REG_BAUD_DIV))
            baud_div <= clamp_div(i_mmio_data[15:0]);
    end

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (tx_push),
        .push_data (i_mmio_data[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Pop in IDLE, or at the end of STOP so back-to-back frames have no gap.
    assign fifo_pop = !fifo_empty &&
                      ((tx_state == TX_IDLE) || ((tx_state == TX_STOP) && (tx_cnt == 16'd0)));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_shift <= '0;
            tx_bit   <= '0;
            o_tx     <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (!fifo_empty) begin
                        tx_shift <= fifo_data;
                        tx_cnt   <= baud_div - 16'd1;
                        o_tx     <= 1'b0;
                        tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_cnt == 16'd0) begin
                        tx_cnt   <= baud_div - 16'd1;
                        o_tx     <= tx_shift[0];
                        tx_bit   <= 3'd0;
                        tx_state <= TX_DATA;
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                TX_DATA: begin
                    if (tx_cnt == 16'd0) begin
                        tx_cnt <= baud_div - 16'd1;
                        if (tx_bit == 3'd7) begin
                            o_tx     <= 1'b1;
                            tx_state <= TX_STOP;
                        end else begin
                            tx_shift <= tx_shift >> 1;
                            o_tx     <= tx_shift[1];
                            tx_bit   <= tx_bit + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                TX_STOP: begin
                    if (tx_cnt == 16'd0) begin
                        if (!fifo_empty) begin
                            tx_shift <= fifo_data;
                            tx_cnt   <= baud_div - 16'd1;
                            o_tx     <= 1'b0;
                            tx_state <= TX_START;
                        end else begin
                            tx_state <= TX_IDLE;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 16'd1;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= i_rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_shift <= '0;
            rx_bit   <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
            ferr     <= 1'b0;
        end else begin
            if (rx_pop)
                rx_valid <= 1'b0;
            if (sts_wr && i_mmio_data[ST_OVERRUN])
                overrun <= 1'b0;
            if (sts_wr && i_mmio_data[ST_FERR])
                ferr <= 1'b0;

            case (rx_state)
                RX_IDLE: begin
                    if (rx_d && !rx_s2) begin
                        rx_cnt   <= (baud_div >> 1) - 16'd1;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt == 16'd0) begin
                        if (!rx_s2) begin
                            rx_cnt   <= baud_div - 16'd1;
                            rx_bit   <= 3'd0;
                            rx_state <= RX_DATA;
                        end else begin
                            rx_state <= RX_IDLE;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == 16'd0) begin
                        rx_shift <= {rx_s2, rx_shift[7:1]};
                        rx_cnt   <= baud_div - 16'd1;
                        if (rx_bit == 3'd7)
                            rx_state <= RX_STOP;
                        else
                            rx_bit <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == 16'd0) begin
                        rx_state <= RX_IDLE;
                        if (rx_s2) begin
                            // A same-cycle RXDATA pop frees the holding register for the new byte.
                            if (!rx_valid || rx_pop) begin
                                rx_byte  <= rx_shift;
                                rx_valid <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            ferr <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 16'd1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart.sv
// tb/tb_mmio_uart.sv - directed self-checking bench for mmio_uart with BAUD_DIV=4
module tb_mmio_uart;

    localparam logic [31:0] A_TX = 32'hFFFF_0000;
    localparam logic [31:0] A_RX = 32'hFFFF_0004;
    localparam logic [31:0] A_ST = 32'hFFFF_0008;
    localparam logic [31:0] A_BD = 32'hFFFF_000C;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] rdata;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic        tx;
    logic        rx = 1'b1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mmio_uart #(
        .BASE_ADDR   (32'hFFFF_0000),
        .TX_DEPTH    (4),
        .DEFAULT_DIV (16'd868),
        .DATA_WIDTH  (32)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_mmio_addr     (addr),
        .i_mmio_data     (wdata),
        .i_mmio_wr_valid (wr_valid),
        .o_mmio_wr_ready (wr_ready),
        .o_mmio_data     (rdata),
        .o_mmio_rd_valid (rd_valid),
        .i_mmio_rd_ready (rd_ready),
        .o_tx            (tx),
        .i_rx            (rx)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, output logic rdy);
        @(negedge clk);
        addr = a; wdata = d; wr_valid = 1'b1;
        #1 rdy = wr_ready;
        @(posedge clk);
        #1 wr_valid = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic v);
        @(negedge clk);
        addr = a; rd_ready = 1'b1;
        #1 d = rdata; v = rd_valid;
        @(posedge clk);
        #1 rd_ready = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic v;
        rd(a, d, v);
        check({name, "_valid"}, {31'b0, v}, 32'd1);
        check(name, d, exp);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (4) @(negedge clk);
        end
        rx = stop;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Serial monitor: decodes o_tx frames at mid-bit into a queue.
    logic [7:0] tx_q[$];
    bit mon_en = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !rst && tx == 1'b0) begin
                logic [7:0] b;
                @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = tx;
                end
                repeat (4) @(negedge clk);
                tx_q.push_back(b);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          is_wr;
        logic [31:0] a;
        logic [31:0] d;
        logic        exp_hs;
        logic [31:0] exp_rd;
        string       name;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic        hs;
        logic [31:0] d;
        logic [9:0]  exp_bits;
        logic [3:0]  samp;
        logic [5:0]  exp_rdy;
        int          n;
        bit          stayed_high;

        vecs[0]  = '{1'b0, A_ST,         32'h0, 1'b1, 32'h0000_0002, "status_reset"};
        vecs[1]  = '{1'b0, A_BD,         32'h0, 1'b1, 32'h0000_0364, "baud_reset"};
        vecs[2]  = '{1'b0, A_RX,         32'h0, 1'b1, 32'h0000_0000, "rxdata_empty"};
        vecs[3]  = '{1'b1, 32'hFFFF_0010, 32'h5, 1'b0, 32'h0, "wr_base_plus_10"};
        vecs[4]  = '{1'b0, 32'hFFFF_0010, 32'h0, 1'b0, 32'h0, "rd_base_plus_10"};
        vecs[5]  = '{1'b0, 32'h8888_8888, 32'h0, 1'b0, 32'h0, "rd_foreign"};
        vecs[6]  = '{1'b1, 32'h8888_8888, 32'h4, 1'b0, 32'h0, "wr_foreign"};
        vecs[7]  = '{1'b1, A_BD,         32'h1, 1'b1, 32'h0, "wr_baud_1"};
        vecs[8]  = '{1'b0, A_BD,         32'h0, 1'b1, 32'h0000_0002, "baud_clamped"};
        vecs[9]  = '{1'b1, A_BD,         32'h4, 1'b1, 32'h0, "wr_baud_4"};
        vecs[10] = '{1'b0, A_BD,         32'h0, 1'b1, 32'h0000_0004, "baud_4"};
        vecs[11] = '{1'b1, A_ST,         32'h3F, 1'b1, 32'h0, "wr_status_all"};
        vecs[12] = '{1'b0, A_ST,         32'h0, 1'b1, 32'h0000_0002, "status_idle"};

        rst = 1'b1;
        #1 check("reset_tx_high", {31'b0, tx}, 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            if (vecs[i].is_wr) begin
                wr(vecs[i].a, vecs[i].d, hs);
                check({vecs[i].name, "_ready"}, {31'b0, hs}, {31'b0, vecs[i].exp_hs});
            end else begin
                rd(vecs[i].a, d, hs);
                check({vecs[i].name, "_valid"}, {31'b0, hs}, {31'b0, vecs[i].exp_hs});
                check({vecs[i].name, "_data"}, d, vecs[i].exp_rd);
            end
        end

        // Single frame 0x55 (upper write bits must be ignored).
        wr(A_TX, 32'h0000_0155, hs);
        check("tx55_ready", {31'b0, hs}, 32'd1);
        n = 0;
        while (tx !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("tx55_start_seen", {31'b0, (n < 20)}, 32'd1);
        exp_bits = 10'b10_1010_1010;
        for (int b = 0; b < 10; b++) begin
            for (int k = 0; k < 4; k++) begin
                samp[k] = tx;
                @(negedge clk);
            end
            check($sformatf("tx55_bit%0d", b), {28'b0, samp}, {28'b0, {4{exp_bits[b]}}});
        end
        rd_chk("tx55_status_empty", A_ST, 32'h0000_0002);

        // Burst of six: one goes to the shifter, four fill the FIFO, the sixth stalls.
        tx_q.delete();
        mon_en = 1'b1;
        exp_rdy = 6'b01_1111;
        for (int i = 0; i < 6; i++) begin
            wr(A_TX, i + 1, hs);
            check($sformatf("burst_ready%0d", i), {31'b0, hs}, {31'b0, exp_rdy[i]});
        end
        n = 0;
        hs = 1'b0;
        while (!hs && n < 200) begin
            wr(A_TX, 32'h6, hs);
            n++;
        end
        check("burst_6th_accepted", {31'b0, hs}, 32'd1);
        n = 0;
        while (tx_q.size() < 6 && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("burst_frame_count", tx_q.size(), 32'd6);
        for (int i = 0; i < 6 && i < tx_q.size(); i++)
            check($sformatf("burst_byte%0d", i), {24'b0, tx_q[i]}, i + 1);
        mon_en = 1'b0;
        repeat (10) @(negedge clk);
        rd_chk("burst_status_empty", A_ST, 32'h0000_0002);

        // Receive path.
        send_frame(8'hA5, 1'b1);
        rd_chk("rx_a5_status", A_ST, 32'h0000_000A);
        rd_chk("rx_a5_data", A_RX, 32'h0000_00A5);
        rd_chk("rx_a5_status_after", A_ST, 32'h0000_0002);
        rd_chk("rx_empty_read", A_RX, 32'h0000_0000);

        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        rd_chk("overrun_status", A_ST, 32'h0000_001A);
        rd_chk("overrun_data", A_RX, 32'h0000_0011);
        rd_chk("overrun_sticky", A_ST, 32'h0000_0012);
        wr(A_ST, 32'h10, hs);
        check("clr_overrun_ready", {31'b0, hs}, 32'd1);
        rd_chk("overrun_cleared", A_ST, 32'h0000_0002);

        send_frame(8'h3C, 1'b0);
        rd_chk("ferr_status", A_ST, 32'h0000_0022);
        wr(A_ST, 32'h20, hs);
        rd_chk("ferr_cleared", A_ST, 32'h0000_0002);

        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        rd_chk("glitch_ignored", A_ST, 32'h0000_0002);

        // Reset in the middle of a frame with a byte still queued.
        wr(A_TX, 32'hAA, hs);
        wr(A_TX, 32'hBB, hs);
        rd_chk("pre_reset_status", A_ST, 32'h0000_0004);
        @(negedge clk);
        check("pre_reset_tx_low", {31'b0, tx}, 32'd0);
        #2 rst = 1'b1;
        #1 check("reset_tx_immediate", {31'b0, tx}, 32'd1);
        addr = A_ST;
        rd_ready = 1'b1;
        #1 check("reset_status_comb", rdata, 32'h0000_0002);
        rd_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stayed_high = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) stayed_high = 1'b0;
        end
        check("post_reset_tx_idle", {31'b0, stayed_high}, 32'd1);
        rd_chk("post_reset_status", A_ST, 32'h0000_0002);
        rd_chk("post_reset_baud", A_BD, 32'h0000_0364);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
